lfsr8_launcher: RTL and testbench

LFSR8_LAUNCHER -- requirements
Module: lfsr8_launcher

---
 rtl/lfsr8_launcher.sv | 96 +++++++++
 tb/tb_lfsr8_launcher.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr8_launcher.sv
// rtl/lfsr8_launcher.sv - 8-bit Galois-free Fibonacci LFSR stepped by a debounced button,
// an auto-step divider or overwritten by a seed load.
module lfsr8_launcher #(
  parameter logic [15:0] DB_CNT   = 16'd1000,
  parameter logic [23:0] AUTO_DIV = 24'd5000000,
  parameter logic [7:0]  SEED     = 8'h01
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn,
  input  logic       auto_en,
  input  logic       load,
  input  logic [7:0] seed_in,
  output logic [7:0] num,
  output logic       num_vld
);

  // An all-zero LFSR would lock up, so a zero seed is forced to 1.
  localparam logic [7:0] SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;

  logic        sync1_q, sync2_q;
  logic        deb_q, deb_d;
  logic        deb_prev_q;
  logic [15:0] db_cnt_q, db_cnt_d;
  logic [23:0] div_q, div_d;
  logic [7:0]  num_q, num_d;
  logic        vld_q, vld_d;
  logic        btn_step, auto_step, step;

  always_comb begin
    deb_d    = deb_q;
    db_cnt_d = '0;
    if (sync2_q != deb_q) begin
      if (db_cnt_q == DB_CNT - 16'd1) begin
        deb_d = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + 16'd1;
      end
    end
  end

  // The rising edge is taken from registered levels so a press costs DB_CNT+3 edges in total.
  assign btn_step = deb_q & ~deb_prev_q;

  always_comb begin
    div_d     = '0;
    auto_step = 1'b0;
    if (auto_en) begin
      if (div_q == AUTO_DIV - 24'd1) begin
        auto_step = 1'b1;
      end else begin
        div_d = div_q + 24'd1;
      end
    end
  end

  assign step = btn_step | auto_step;

  always_comb begin
    num_d = num_q;
    vld_d = 1'b0;
    if (load) begin
      num_d = (seed_in == 8'h00) ? 8'h01 : seed_in;
      vld_d = 1'b1;
    end else if (step) begin
      num_d = {num_q[4] ^ num_q[3] ^ num_q[2] ^ num_q[0], num_q[7:1]};
      vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
      db_cnt_q   <= '0;
      div_q      <= '0;
      num_q      <= SEED_EFF;
      vld_q      <= 1'b0;
    end else begin
      sync1_q    <= btn;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      db_cnt_q   <= db_cnt_d;
      div_q      <= div_d;
      num_q      <= num_d;
      vld_q      <= vld_d;
    end
  end

  assign num     = num_q;
  assign num_vld = vld_q;

endmodule

// File: tb/tb_lfsr8_launcher.sv
// tb/tb_lfsr8_launcher.sv - directed bench with a cycle model of lfsr8_launcher
module tb_lfsr8_launcher;

  localparam int DB  = 4;
  localparam int DIV = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn;
  logic       auto_en;
  logic       load;
  logic [7:0] seed_in;
  logic [7:0] num;
  logic       num_vld;

  int errors = 0;
  int checks = 0;

  lfsr8_launcher #(.DB_CNT(16'd4), .AUTO_DIV(24'd8), .SEED(8'h01)) dut (
    .clk(clk), .rst_n(rst_n), .btn(btn), .auto_en(auto_en), .load(load),
    .seed_in(seed_in), .num(num), .num_vld(num_vld)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] lfsr_next(input logic [7:0] n);
    return {n[4] ^ n[3] ^ n[2] ^ n[0], n[7:1]};
  endfunction

  // Model: btn history window, debounced level flips when the whole synchronized window disagrees.
  logic [7:0] m_num;
  logic       m_vld;
  logic       m_deb;
  logic       m_pend;
  int         m_cyc;
  logic       m_h [0:DB+1];

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_num  = 8'h01;
        m_vld  = 1'b0;
        m_deb  = 1'b0;
        m_pend = 1'b0;
        m_cyc  = 0;
        for (int k = 0; k <= DB + 1; k++) m_h[k] = 1'b0;
      end else begin
        logic do_step;
        logic flip;
        do_step = m_pend;
        for (int k = DB + 1; k > 0; k--) m_h[k] = m_h[k-1];
        m_h[0] = btn;
        flip = 1'b1;
        for (int k = 2; k <= DB + 1; k++) if (m_h[k] == m_deb) flip = 1'b0;
        m_pend = flip && !m_deb;
        if (flip) m_deb = !m_deb;
        if (auto_en) begin
          m_cyc++;
          if (m_cyc % DIV == 0) do_step = 1'b1;
        end else begin
          m_cyc = 0;
        end
        if (load) begin
          m_num = (seed_in == 8'h00) ? 8'h01 : seed_in;
          m_vld = 1'b1;
        end else if (do_step) begin
          m_num = lfsr_next(m_num);
          m_vld = 1'b1;
        end else begin
          m_vld = 1'b0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      chk("model_num", {24'd0, num}, {24'd0, m_num});
      chk("model_vld", {31'd0, num_vld}, {31'd0, m_vld});
    end
  end

  task automatic run(input int n, output int p);
    p = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
      if (num_vld) p++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1);
  end

  initial begin
    int p;
    int distinct;
    logic seen [0:255];
    rst_n = 1'b0; btn = 1'b0; auto_en = 1'b0; load = 1'b0; seed_in = 8'h00;
    repeat (2) @(posedge clk);
    #2;
    chk("reset_num", {24'd0, num}, 32'h01);
    chk("reset_vld", {31'd0, num_vld}, 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // Three-cycle glitch never qualifies.
    @(negedge clk) btn = 1'b1;
    repeat (3) @(negedge clk);
    btn = 1'b0;
    run(12, p);
    chk("glitch_num", {24'd0, num}, 32'h01);
    chk("glitch_pulses", p, 32'd0);

    // Clean press: update on edge 7.
    @(negedge clk) btn = 1'b1;
    run(6, p);
    chk("press_pre_num", {24'd0, num}, 32'h01);
    chk("press_pre_pulses", p, 32'd0);
    @(posedge clk); #2;
    chk("press_num", {24'd0, num}, 32'h80);
    chk("press_vld", {31'd0, num_vld}, 32'd1);
    @(posedge clk); #2;
    chk("press_vld_drop", {31'd0, num_vld}, 32'd0);
    run(20, p);
    chk("hold_pulses", p, 32'd0);
    @(negedge clk) btn = 1'b0;
    run(10, p);
    @(negedge clk) btn = 1'b1;
    run(10, p);
    chk("press2_num", {24'd0, num}, 32'h40);
    chk("press2_pulses", p, 32'd1);
    @(negedge clk) btn = 1'b0;
    run(10, p);

    // Zero seed load, then load coinciding with an auto wrap.
    @(negedge clk) begin load = 1'b1; seed_in = 8'h00; end
    @(posedge clk); #2;
    chk("load0_num", {24'd0, num}, 32'h01);
    chk("load0_vld", {31'd0, num_vld}, 32'd1);
    @(negedge clk) begin load = 1'b0; auto_en = 1'b1; end
    repeat (7) @(negedge clk);
    load = 1'b1; seed_in = 8'hA5;
    @(posedge clk); #2;
    chk("loadA5_num", {24'd0, num}, 32'hA5);
    chk("loadA5_vld", {31'd0, num_vld}, 32'd1);
    @(negedge clk) begin load = 1'b0; auto_en = 1'b0; end
    @(posedge clk); #2;
    chk("loadA5_no_step", {24'd0, num}, 32'hA5);
    chk("loadA5_vld_drop", {31'd0, num_vld}, 32'd0);
    @(negedge clk) load = 1'b1;
    @(posedge clk); #2;
    chk("load_same_vld", {31'd0, num_vld}, 32'd1);
    @(negedge clk) begin load = 1'b1; seed_in = 8'h01; end
    @(negedge clk) begin load = 1'b0; auto_en = 1'b1; end

    // Full period under auto stepping.
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    p = 0;
    distinct = 0;
    for (int i = 0; i < 255 * DIV; i++) begin
      @(posedge clk); #2;
      if (num_vld) begin
        p++;
        if (num != 8'h00 && !seen[num]) distinct++;
        seen[num] = 1'b1;
      end
    end
    chk("period_pulses", p, 32'd255);
    chk("period_distinct", distinct, 32'd255);
    chk("period_final", {24'd0, num}, 32'h01);
    @(negedge clk) auto_en = 1'b0;

    // Button step landing on the divider wrap.
    @(negedge clk) auto_en = 1'b1;
    @(negedge clk) btn = 1'b1;
    run(7, p);
    chk("coinc_pulses", p, 32'd1);
    chk("coinc_num", {24'd0, num}, 32'h80);
    @(negedge clk) begin auto_en = 1'b0; btn = 1'b0; end
    run(10, p);

    // Reset during debounce count 2.
    @(negedge clk) btn = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b0; btn = 1'b0;
    #1;
    chk("midreset_num", {24'd0, num}, 32'h01);
    chk("midreset_vld", {31'd0, num_vld}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    run(15, p);
    chk("midreset_pulses", p, 32'd0);
    chk("midreset_after", {24'd0, num}, 32'h01);

    // Button already high at reset release.
    @(negedge clk) begin rst_n = 1'b0; btn = 1'b1; end
    @(negedge clk) rst_n = 1'b1;
    run(6, p);
    chk("held_pre_num", {24'd0, num}, 32'h01);
    @(posedge clk); #2;
    chk("held_num", {24'd0, num}, 32'h80);
    chk("held_vld", {31'd0, num_vld}, 32'd1);
    @(negedge clk) btn = 1'b0;
    run(10, p);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
